// File: rtl/instruction_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, program memory/IR and execute stage.
// master = sequencer side, slave = memory/IR/execute side.
interface instruction_fetch_sequencer_if #(
    parameter int OPCODE_WIDTH = 5
);
    logic                    mem_ready;
    logic [15:0]             ir_value;
    logic                    exec_done;
    logic                    halt_req;
    logic                    mem_read;
    logic                    ir_load;
    logic                    pc_inc;
    logic                    exec_start;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [15:0]             instr_count;
    logic                    halted;
    logic                    mem_fault;

    modport master (
        input  mem_ready, ir_value, exec_done, halt_req,
        output mem_read, ir_load, pc_inc, exec_start,
        output opcode, instr_count, halted, mem_fault
    );

    modport slave (
        output mem_ready, ir_value, exec_done, halt_req,
        input  mem_read, ir_load, pc_inc, exec_start,
        input  opcode, instr_count, halted, mem_fault
    );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Fetch/load/decode/execute control FSM driving the IR load enable,
// with HALT detection and memory time-out fault.
module instruction_fetch_sequencer #(
    parameter int                    OPCODE_WIDTH   = 5,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = 5'h1F,
    parameter int                    TIMEOUT_CYCLES = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    instruction_fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_DECODE,
        S_EXECUTE, S_HALT, S_FAULT
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  state;
    state_t                  state_n;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [15:0]             count_q;
    logic [TW-1:0]           to_cnt;
    logic                    first_q;
    logic [OPCODE_WIDTH-1:0] field;
    logic                    timeout;

    assign field   = bus.ir_value[15 -: OPCODE_WIDTH];
    // Hitting the last allowed wait edge without data means the fault edge.
    assign timeout = (TIMEOUT_CYCLES > 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            opcode_q <= '0;
            count_q  <= '0;
            to_cnt   <= '0;
            first_q  <= 1'b0;
        end else begin
            state   <= state_n;
            to_cnt  <= (state == S_FETCH) ? to_cnt + 1'b1 : '0;
            first_q <= (state == S_DECODE);
            if (state == S_DECODE)
                opcode_q <= field;
            if (state == S_EXECUTE && bus.exec_done)
                count_q <= count_q + 16'd1;
        end
    end

    always_comb begin
        state_n        = state;
        bus.mem_read   = 1'b0;
        bus.ir_load    = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.exec_start = 1'b0;
        bus.halted     = 1'b0;
        bus.mem_fault  = 1'b0;
        unique case (state)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready)
                    state_n = S_LOAD;
                else if (timeout)
                    state_n = S_FAULT;
            end
            S_LOAD: begin
                bus.ir_load = 1'b1;
                bus.pc_inc  = 1'b1;
                state_n     = S_DECODE;
            end
            S_DECODE:
                state_n = (field == HALT_OPCODE) ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                bus.exec_start = first_q;
                if (bus.exec_done)
                    state_n = bus.halt_req ? S_HALT : S_FETCH;
            end
            S_HALT:  bus.halted    = 1'b1;
            S_FAULT: bus.mem_fault = 1'b1;
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.opcode      = opcode_q;
    assign bus.instr_count = count_q;
endmodule

// File: doc/instruction_fetch_sequencer.md
# instruction_fetch_sequencer

Multi-cycle control FSM that sequences the 16-bit instruction register and its surroundings: it requests an instruction word from memory, pulses `ir_load`, decodes the opcode field from the IR output, and hands off to the execute stage. It sits between program memory/PC and the instruction register, driving the IR's load enable. It also detects HALT and memory time-outs.

## Interface
Parameters:
- `OPCODE_WIDTH`, 5: opcode field width, taken from `ir_value[15:16-OPCODE_WIDTH]`.
- `HALT_OPCODE`, 5'h1F: opcode that stops the sequencer.
- `TIMEOUT_CYCLES`, 15: consecutive not-ready FETCH cycles before a fault; 0 disables the time-out.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_ready`  in  1  memory has valid instruction data this cycle.
- `ir_value`  in  16  instruction register output (`out_value` of the IR).
- `exec_done`  in  1  execute stage has finished the current instruction.
- `halt_req`  in  1  external halt request.
- `mem_read`  out  1  instruction read request.
- `ir_load`  out  1  IR load enable.
- `pc_inc`  out  1  PC increment strobe.
- `exec_start`  out  1  one-cycle start pulse to execute stage.
- `opcode`  out  OPCODE_WIDTH  latched opcode of current instruction.
- `instr_count`  out  16  retired-instruction counter.
- `halted`  out  1  sequencer in HALT.
- `mem_fault`  out  1  sequencer in FAULT.

## Operation
- States: IDLE, FETCH, LOAD, DECODE, EXECUTE, HALT, FAULT.
- Reset: state=IDLE; `opcode`=0, `instr_count`=0, time-out counter=0; every output is 0.
- IDLE → FETCH unconditionally on the next edge with `reset`=0.
- FETCH: `mem_read`=1. If `mem_ready`=1 at the edge, go to LOAD. Else increment the time-out counter. If the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0), go to FAULT. `mem_ready`=1 on the time-out edge wins: go to LOAD. The counter clears on every entry to FETCH.
- LOAD: `ir_load`=1, `pc_inc`=1, for exactly one cycle → DECODE.
- DECODE: `opcode` <= top OPCODE_WIDTH bits of `ir_value`. If that field == HALT_OPCODE → HALT; else → EXECUTE. The count is not incremented on HALT.
- EXECUTE: `exec_start`=1 in the first EXECUTE cycle only. On `exec_done`=1 at an edge, `instr_count` += 1 (wraps FFFF→0000), then:
  - go to HALT if `halt_req`=1 at that edge;
  - else go to FETCH.
- `exec_done` in the same cycle as `exec_start` is legal and gives a 1-cycle EXECUTE. `exec_done` outside EXECUTE is ignored.
- `halt_req` is sampled only at EXECUTE completion; it is ignored in all other states.
- HALT: `halted`=1. FAULT: `mem_fault`=1. Both are terminal; only `reset` leaves them.
- `mem_read`, `ir_load`, `pc_inc`, `halted` and `mem_fault` are Moore outputs decoded from state (registered state, no input-to-output paths).

## Timing
- Minimum instruction period: 4 cycles (FETCH with ready, LOAD, DECODE, 1-cycle EXECUTE).
- Latency:
  - `ir_load` is high the cycle after the edge that samples `mem_ready`=1.
  - IR data is valid on `ir_value` in DECODE.
  - `opcode` is valid from the first EXECUTE cycle.
- Reset asserted in any state takes effect at the next edge. Any pending EXECUTE or FETCH is abandoned and no count is retired.
- Fault timing: with TIMEOUT_CYCLES=N and `mem_ready` held low, FAULT is entered on the N-th FETCH edge, and `mem_fault`=1 in the following cycle.

## Test plan
- Basic fetch: reset, `mem_ready`=1, `ir_value`=16'h0A55 in DECODE, `exec_done`=1 in first EXECUTE → one `ir_load` pulse, `opcode`=5'h01, `instr_count`=1, back in FETCH 4 cycles after the first FETCH.
- Wait states: `mem_ready` low for 3 FETCH cycles then high → `mem_read` held 4 cycles, single `ir_load`/`pc_inc` pulse, no fault.
- Time-out: TIMEOUT_CYCLES=15, `mem_ready` stuck 0 → `mem_fault`=1 after 15 FETCH cycles; stays 1 until reset, then IDLE with all outputs 0.
- HALT opcode: `ir_value`=16'hF800 → HALT, `halted`=1, `exec_start` never pulses, `instr_count` unchanged.
- halt_req: `halt_req`=1 asserted during FETCH then dropped → no effect. `halt_req`=1 coincident with `exec_done` → count increments, HALT entered.
- Wrap and mid-reset:
  - preload via 65535 retired instructions, retire one more → `instr_count`=16'h0000;
  - reset during EXECUTE → IDLE, `instr_count`=0.
